// File: rtl/uart_reg_arbiter.sv
// uart_reg_arbiter: serialises single-register transactions from two requesters
// onto the UART register bank and returns read data or a write acknowledge.
module uart_reg_arbiter #(
    parameter int unsigned PRIO_FIXED = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rq0_valid,
    output logic       rq0_ready,
    input  logic       rq0_write,
    input  logic [2:0] rq0_addr,
    input  logic [7:0] rq0_wdata,
    input  logic       rq1_valid,
    output logic       rq1_ready,
    input  logic       rq1_write,
    input  logic [2:0] rq1_addr,
    input  logic [7:0] rq1_wdata,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_rdata,
    output logic       rsp0_err,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_rdata,
    output logic       rsp1_err,
    output logic       rb_w_e,
    output logic       rb_r_e,
    output logic [7:0] rb_w_addr,
    output logic [7:0] rb_r_addr,
    output logic [7:0] rb_w_data,
    input  logic [7:0] rb_r_data,
    input  logic       tx_full
);

    localparam int unsigned AW  = 3;
    localparam int unsigned DW  = 8;
    localparam int unsigned BAW = 8;
    localparam logic [AW-1:0] IDX_FSR = AW'(5);
    localparam logic [AW-1:0] IDX_TBR = AW'(6);
    localparam logic [AW-1:0] IDX_RBR = AW'(7);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic            write_q, write_d;
    logic            ro_err_q, ro_err_d;

    logic            rsp0_valid_d, rsp1_valid_d;
    logic [DW-1:0]   rsp0_rdata_d, rsp1_rdata_d;
    logic            rsp0_err_d, rsp1_err_d;
    logic            rb_w_e_d, rb_r_e_d;
    logic [BAW-1:0]  rb_w_addr_d, rb_r_addr_d;
    logic [DW-1:0]   rb_w_data_d;

    logic            elig0, elig1, grant0, grant1;
    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_ro;
    logic [DW-1:0]   issue_rdata;

    // Eligibility and grant; a TBR write is held off while the transmitter is full
    always_comb begin
        elig0  = rq0_valid && !(rq0_write && (rq0_addr == IDX_TBR) && tx_full);
        elig1  = rq1_valid && !(rq1_write && (rq1_addr == IDX_TBR) && tx_full);
        grant0 = elig0 && (!elig1 || (PRIO_FIXED != 0) || last_grant_q);
        grant1 = elig1 && !grant0;
        rq0_ready = (state_q == IDLE) && grant0;
        rq1_ready = (state_q == IDLE) && grant1;
        sel_write = grant1 ? rq1_write : rq0_write;
        sel_addr  = grant1 ? rq1_addr  : rq0_addr;
        sel_wdata = grant1 ? rq1_wdata : rq0_wdata;
        sel_ro    = (sel_addr == IDX_FSR) || (sel_addr == IDX_RBR);
    end

    // Next-state and next-output logic; every output defaults to 0 each cycle
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        write_d      = write_q;
        ro_err_d     = ro_err_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = '0;
        rsp1_rdata_d = '0;
        rsp0_err_d   = 1'b0;
        rsp1_err_d   = 1'b0;
        rb_w_e_d     = 1'b0;
        rb_r_e_d     = 1'b0;
        rb_w_addr_d  = '0;
        rb_r_addr_d  = '0;
        rb_w_data_d  = '0;
        issue_rdata  = write_q ? '0 : rb_r_data;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d      = ISSUE;
                    last_grant_d = grant1;
                    owner_d      = grant1;
                    write_d      = sel_write;
                    ro_err_d     = sel_write && sel_ro;
                    if (sel_write && !sel_ro) begin
                        rb_w_e_d    = 1'b1;
                        rb_w_addr_d = BAW'(sel_addr);
                        rb_w_data_d = sel_wdata;
                    end else if (!sel_write) begin
                        rb_r_e_d    = 1'b1;
                        rb_r_addr_d = BAW'(sel_addr);
                    end
                end
            end
            ISSUE: begin
                state_d = RESP;
                if (owner_q) begin
                    rsp1_valid_d = 1'b1;
                    rsp1_rdata_d = issue_rdata;
                    rsp1_err_d   = ro_err_q;
                end else begin
                    rsp0_valid_d = 1'b1;
                    rsp0_rdata_d = issue_rdata;
                    rsp0_err_d   = ro_err_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, transaction and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            ro_err_q     <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp0_rdata   <= '0;
            rsp1_rdata   <= '0;
            rsp0_err     <= 1'b0;
            rsp1_err     <= 1'b0;
            rb_w_e       <= 1'b0;
            rb_r_e       <= 1'b0;
            rb_w_addr    <= '0;
            rb_r_addr    <= '0;
            rb_w_data    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            ro_err_q     <= ro_err_d;
            rsp0_valid   <= rsp0_valid_d;
            rsp1_valid   <= rsp1_valid_d;
            rsp0_rdata   <= rsp0_rdata_d;
            rsp1_rdata   <= rsp1_rdata_d;
            rsp0_err     <= rsp0_err_d;
            rsp1_err     <= rsp1_err_d;
            rb_w_e       <= rb_w_e_d;
            rb_r_e       <= rb_r_e_d;
            rb_w_addr    <= rb_w_addr_d;
            rb_r_addr    <= rb_r_addr_d;
            rb_w_data    <= rb_w_data_d;
        end
    end

endmodule

// File: tb/tb_uart_reg_arbiter.sv
// Scoreboard bench for uart_reg_arbiter: accepts push expected bank ops and
// responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_uart_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rq0_valid, rq0_ready, rq0_write;
    logic [2:0] rq0_addr;
    logic [7:0] rq0_wdata;
    logic       rq1_valid, rq1_ready, rq1_write;
    logic [2:0] rq1_addr;
    logic [7:0] rq1_wdata;
    logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic       rb_w_e, rb_r_e;
    logic [7:0] rb_w_addr, rb_r_addr, rb_w_data, rb_r_data;
    logic       tx_full;

    typedef struct { int port; int cyc; logic [7:0] rdata; logic err; } rsp_t;
    typedef struct { int cyc; logic we; logic [2:0] addr; logic [7:0] data; } bank_t;
    typedef struct { int port; int cyc; } grant_t;

    rsp_t   rsp_q[$];
    bank_t  bank_q[$];
    grant_t grant_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Bank read model: fixed contents per index
    function automatic logic [7:0] bank_val(input logic [2:0] a);
        case (a)
            3'd3:    return 8'h3C;
            3'd5:    return 8'h60;
            3'd7:    return 8'hA5;
            default: return 8'h10 + {5'b0, a};
        endcase
    endfunction

    assign rb_r_data = bank_val(rb_r_addr[2:0]);

    uart_reg_arbiter #(.PRIO_FIXED(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_write(rq0_write),
        .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_write(rq1_write),
        .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .rb_w_e(rb_w_e), .rb_r_e(rb_r_e), .rb_w_addr(rb_w_addr), .rb_r_addr(rb_r_addr),
        .rb_w_data(rb_w_data), .rb_r_data(rb_r_data), .tx_full(tx_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one request on a port, wait (bounded) for accept, push expectations
    task automatic do_req(input int port, input logic w, input logic [2:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd, input logic exp_err);
        bit    got = 1'b0;
        rsp_t  r;
        bank_t b;
        grant_t g;
        if (port == 0) begin
            rq0_write = w; rq0_addr = a; rq0_wdata = d; rq0_valid = 1'b1;
        end else begin
            rq1_write = w; rq1_addr = a; rq1_wdata = d; rq1_valid = 1'b1;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((port == 0) ? rq0_ready : rq1_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk($sformatf("accept_timeout_p%0d", port), {31'b0, got}, 32'd1);
        if (got) begin
            r.port = port; r.cyc = cyc + 2; r.rdata = exp_rd; r.err = exp_err;
            rsp_q.push_back(r);
            if (!(w && (a == 3'd5 || a == 3'd7))) begin
                b.cyc = cyc + 1; b.we = w; b.addr = a; b.data = w ? d : 8'h00;
                bank_q.push_back(b);
            end
            g.port = port; g.cyc = cyc;
            grant_log.push_back(g);
        end
        @(posedge clk);
        #1;
        if (port == 0) rq0_valid = 1'b0; else rq1_valid = 1'b0;
    endtask

    // Monitor: pops and compares bank strobes and responses, plus per-cycle invariants
    always @(negedge clk) begin
        rsp_t  r;
        bank_t b;
        if (rq0_valid && rq1_valid)
            chk("both_ready", {31'b0, rq0_ready & rq1_ready}, 32'd0);
        if (!rb_r_e) chk("r_addr_idle", {24'b0, rb_r_addr}, 32'd0);
        if (!rb_w_e) chk("w_idle", {16'b0, rb_w_addr, rb_w_data}, 32'd0);
        if (rb_w_e || rb_r_e) begin
            if (bank_q.size() == 0) begin
                chk("bank_unexpected", {30'b0, rb_w_e, rb_r_e}, 32'd0);
            end else begin
                b = bank_q.pop_front();
                chk("bank_cycle", cyc, b.cyc);
                chk("bank_kind", {30'b0, rb_w_e, rb_r_e}, b.we ? 32'd2 : 32'd1);
                if (b.we) chk("bank_w", {16'b0, rb_w_addr, rb_w_data}, {16'b0, 5'b0, b.addr, b.data});
                else      chk("bank_r_addr", {24'b0, rb_r_addr}, {29'b0, b.addr});
            end
        end
        if (rsp0_valid || rsp1_valid) begin
            chk("rsp_both", {31'b0, rsp0_valid & rsp1_valid}, 32'd0);
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_port", rsp1_valid ? 32'd1 : 32'd0, r.port);
                chk("rsp_cycle", cyc, r.cyc);
                if (rsp1_valid) begin
                    chk("rsp1_rdata", {24'b0, rsp1_rdata}, {24'b0, r.rdata});
                    chk("rsp1_err", {31'b0, rsp1_err}, {31'b0, r.err});
                    chk("rsp0_quiet", {23'b0, rsp0_rdata, rsp0_err}, 32'd0);
                end else begin
                    chk("rsp0_rdata", {24'b0, rsp0_rdata}, {24'b0, r.rdata});
                    chk("rsp0_err", {31'b0, rsp0_err}, {31'b0, r.err});
                    chk("rsp1_quiet", {23'b0, rsp1_rdata, rsp1_err}, 32'd0);
                end
            end
        end else begin
            chk("rsp_idle", {14'b0, rsp0_rdata, rsp0_err, rsp1_rdata, rsp1_err}, 32'd0);
        end
    end

    task automatic chk_all_zero(input string name);
        chk(name, {13'b0, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rb_w_e, rb_r_e,
                   rq0_ready, rq1_ready, rb_r_addr}, 32'd0);
        chk({name, "_w"}, {16'b0, rb_w_addr, rb_w_data}, 32'd0);
    endtask

    initial begin
        bit got;
        rst_n = 1'b0; tx_full = 1'b0;
        rq0_valid = 1'b0; rq0_write = 1'b0; rq0_addr = 3'd0; rq0_wdata = 8'h00;
        rq1_valid = 1'b0; rq1_write = 1'b0; rq1_addr = 3'd0; rq1_wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        @(posedge clk); #1 rst_n = 1'b1;

        // Port 0 write DLL=0x1B
        do_req(0, 1'b1, 3'd1, 8'h1B, 8'h00, 1'b0);
        repeat (3) @(posedge clk); #1;

        // Port 1 reads RBR
        do_req(1, 1'b0, 3'd7, 8'h00, 8'hA5, 1'b0);
        repeat (3) @(posedge clk); #1;

        // Both ports continuously requesting: grants alternate 0,1,0,1, 3 cycles apart
        grant_log.delete();
        fork
            begin
                do_req(0, 1'b1, 3'd0, 8'h01, 8'h00, 1'b0);
                do_req(0, 1'b1, 3'd4, 8'h0F, 8'h00, 1'b0);
            end
            begin
                do_req(1, 1'b0, 3'd1, 8'h00, 8'h11, 1'b0);
                do_req(1, 1'b0, 3'd2, 8'h00, 8'h12, 1'b0);
            end
        join
        chk("alt_count", grant_log.size(), 32'd4);
        if (grant_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("alt_port%0d", i), grant_log[i].port, i % 2);
                if (i > 0) chk($sformatf("alt_gap%0d", i), grant_log[i].cyc - grant_log[i-1].cyc, 32'd3);
            end
        end
        repeat (3) @(posedge clk); #1;

        // Port 0 TBR write blocked by tx_full while port 1 is served
        grant_log.delete();
        tx_full = 1'b1;
        fork
            do_req(0, 1'b1, 3'd6, 8'h55, 8'h00, 1'b0);
            begin
                do_req(1, 1'b0, 3'd3, 8'h00, 8'h3C, 1'b0);
                do_req(1, 1'b0, 3'd3, 8'h00, 8'h3C, 1'b0);
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("tbr_hold", {31'b0, rq0_ready}, 32'd0);
                end
                @(posedge clk); #1 tx_full = 1'b0;
            end
        join
        chk("txf_count", grant_log.size(), 32'd3);
        if (grant_log.size() == 3) begin
            chk("txf_first", grant_log[0].port, 32'd1);
            chk("txf_last", grant_log[2].port, 32'd0);
        end
        repeat (3) @(posedge clk); #1;

        // Port 1 writes read-only FSR: error, no bank strobe
        do_req(1, 1'b1, 3'd5, 8'h77, 8'h00, 1'b1);
        repeat (3) @(posedge clk); #1;

        // Reset during ISSUE of a read: dropped, no response
        rq0_write = 1'b0; rq0_addr = 3'd3; rq0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rq0_ready) begin got = 1'b1; break; end
        end
        chk("rst_accept", {31'b0, got}, 32'd1);
        @(posedge clk); #1;
        rq0_valid = 1'b0;
        chk("rst_issue_strobe", {23'b0, rb_r_e, rb_r_addr}, {23'b0, 1'b1, 8'h03});
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(posedge clk); #1;
        do_req(1, 1'b0, 3'd2, 8'h00, 8'h12, 1'b0);
        repeat (5) @(posedge clk); #1;

        chk("rsp_q_empty", rsp_q.size(), 32'd0);
        chk("bank_q_empty", bank_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
